// File: rtl/ets_sweep_controller.sv
// ETS sweep sequencer: launch a sampler run per phase position, store the count, step the PLL phase, settle.
// Optional watchdog on each sampler run is compiled in with `define SWEEP_TIMEOUT_EN.
module ets_sweep_controller #(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 8,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       sweep_steps,
    output logic              sampler_request_run,
    input  logic              sampler_running,
    input  logic              sampler_result_ready,
    input  logic [31:0]       sampler_result,
    output logic              phase_step,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic [15:0]       steps_completed,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic [2:0]        state_dbg
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_STORE, S_STEP, S_SETTLE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       n_q;
    logic [31:0]       capture_q;
    logic [SET_W-1:0]  settle_q;
    logic [15:0]       count_next;
    logic              timeout_hit;
    logic [31:0]       mem [DEPTH];

    assign count_next = steps_completed + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = (sweep_steps == 16'd0) ? S_DONE : S_LAUNCH;
            S_LAUNCH: if (!sampler_running) state_d = S_WAIT;
            S_WAIT: begin
                if (sampler_result_ready) state_d = S_STORE;
                else if (timeout_hit)     state_d = S_DONE;
            end
            S_STORE:  state_d = (count_next == n_q) ? S_DONE : S_STEP;
            S_STEP:   state_d = S_SETTLE;
            S_SETTLE: if (settle_q == '0) state_d = S_LAUNCH;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        phase_step = (state_q == S_STEP);
        done       = (state_q == S_DONE);
        state_dbg  = state_q;
    end

    // The run request is a registered single-cycle pulse so the sampler never sees it held.
    always_ff @(posedge clk) begin
        if (reset) begin
            sampler_request_run <= 1'b0;
            steps_completed     <= 16'd0;
            n_q                 <= 16'd0;
            capture_q           <= 32'd0;
            settle_q            <= '0;
        end else begin
            sampler_request_run <= (state_q == S_LAUNCH) && !sampler_running;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q             <= (32'(sweep_steps) > DEPTH) ? 16'(DEPTH) : sweep_steps;
                        steps_completed <= 16'd0;
                    end
                end
                S_WAIT:   if (sampler_result_ready) capture_q <= sampler_result;
                S_STORE:  steps_completed <= count_next;
                S_STEP:   settle_q <= SET_W'(SETTLE_CYCLES);
                S_SETTLE: if (settle_q != '0) settle_q <= settle_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Result buffer: not reset; a same-address read during a write returns the old word.
    always_ff @(posedge clk) begin
        if (state_q == S_STORE) mem[steps_completed[ADDR_W-1:0]] <= capture_q;
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data <= 32'd0;
        else       rd_data <= mem[rd_addr];
    end

`ifdef SWEEP_TIMEOUT_EN
    logic [31:0] wd_q;
    logic        timed_out_q;

    assign timeout_hit = (state_q == S_WAIT) && !sampler_result_ready &&
                         (wd_q == 32'(TIMEOUT_CYCLES - 1));
    assign timed_out   = timed_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q        <= 32'd0;
            timed_out_q <= 1'b0;
        end else begin
            if (state_q == S_LAUNCH)    wd_q <= 32'd0;
            else if (state_q == S_WAIT) wd_q <= wd_q + 32'd1;
            if (state_q == S_IDLE && start) timed_out_q <= 1'b0;
            else if (timeout_hit)           timed_out_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
`endif

endmodule

// File: tb/tb_ets_sweep_controller.sv
// Directed + randomized bench for ets_sweep_controller with a behavioural sampler and result scoreboard.
module tb_ets_sweep_controller;
  localparam int DEPTH = 256;
  localparam int ADDR_W = 8;
  localparam int SETTLE = 16;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic reset, start;
  logic [15:0] sweep_steps;
  logic sampler_request_run;
  logic sampler_running = 1'b0;
  logic sampler_result_ready = 1'b0;
  logic [31:0] sampler_result = 32'd0;
  logic phase_step, busy, done, timed_out;
  logic [15:0] steps_completed;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0] rd_data;
  logic [2:0] state_dbg;

  ets_sweep_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETTLE_CYCLES(SETTLE),
                         .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .sweep_steps(sweep_steps),
    .sampler_request_run(sampler_request_run), .sampler_running(sampler_running),
    .sampler_result_ready(sampler_result_ready), .sampler_result(sampler_result),
    .phase_step(phase_step), .busy(busy), .done(done), .timed_out(timed_out),
    .steps_completed(steps_completed), .rd_addr(rd_addr), .rd_data(rd_data),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] plan [512];

  // control from the initial block to the sampler model / monitor
  int clr_seq = 0;
  int hold_req = 0;
  bit mute = 1'b0;

  // sampler model + monitor state (written only by the block below)
  int clr_seen = 0;
  int sm_phase = 0, sm_cnt = 0, hold_cnt = 0, plan_rd = 0;
  int req_cnt = 0, step_cnt = 0, done_cnt = 0, req_wide = 0, spacing_bad = 0;
  int last_step_cyc = 0, last_req_cyc = 0, done_cyc = 0;
  bit req_prev = 1'b0, step_pending = 1'b0;

  always @(negedge clk) begin
    sampler_result_ready = 1'b0;
    if (clr_seq != clr_seen) begin
      clr_seen = clr_seq;
      sm_phase = 0; plan_rd = 0; hold_cnt = hold_req;
      sampler_running = (hold_req > 0);
      req_cnt = 0; step_cnt = 0; done_cnt = 0; req_wide = 0; spacing_bad = 0;
      step_pending = 1'b0; req_prev = 1'b0;
    end else begin
      // monitor
      if (sampler_request_run) begin
        req_cnt++;
        last_req_cyc = cyc;
        if (req_prev) req_wide++;
        if (step_pending && (cyc - last_step_cyc) < SETTLE + 1) spacing_bad++;
        step_pending = 1'b0;
      end
      if (phase_step) begin step_cnt++; last_step_cyc = cyc; step_pending = 1'b1; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      req_prev = sampler_request_run;
      // sampler: random start latency, random run length, one-cycle result pulse
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) sampler_running = 1'b0;
      end else begin
        case (sm_phase)
          0: if (sampler_request_run && !mute) begin sm_phase = 1; sm_cnt = $urandom_range(1, 3); end
          1: begin
            sm_cnt--;
            if (sm_cnt == 0) begin sampler_running = 1'b1; sm_phase = 2; sm_cnt = $urandom_range(2, 12); end
          end
          2: begin
            sm_cnt--;
            if (sm_cnt == 0) begin
              sampler_running = 1'b0;
              sampler_result = plan[plan_rd];
              plan_rd++;
              sampler_result_ready = 1'b1;
              sm_phase = 0;
            end
          end
          default: sm_phase = 0;
        endcase
      end
    end
  end

  // driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon(input int hold);
    hold_req = hold;
    clr_seq++;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_sweep(input int steps, input bit fixed, input int hold);
    int n_exp;
    clear_mon(hold);
    n_exp = (steps > DEPTH) ? DEPTH : steps;
    exp_q.delete();
    for (int i = 0; i < 512; i++) plan[i] = fixed ? 32'(10 * (i + 1)) : $urandom;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(plan[i]);
    sweep_steps = 16'(steps);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag, output int used);
    used = 0;
    while (busy === 1'b1 && used < budget) begin @(negedge clk); used++; end
    check({tag, "_idle_in_budget"}, 32'(busy === 1'b1), 32'd0);
  endtask

  task automatic read_buf(input int a, output logic [31:0] d);
    rd_addr = ADDR_W'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  // scoreboard: the controller's view of the sweep against the sampler's delivered words
  task automatic verify_sweep(input int n_exp, input string tag);
    logic [31:0] d, e;
    check({tag, "_steps_completed"}, 32'(steps_completed), 32'(n_exp));
    check({tag, "_requests"}, 32'(req_cnt), 32'(n_exp));
    check({tag, "_phase_steps"}, 32'(step_cnt), 32'((n_exp > 0) ? n_exp - 1 : 0));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_req_width"}, 32'(req_wide), 32'd0);
    check({tag, "_settle_spacing"}, 32'(spacing_bad), 32'd0);
    check({tag, "_timed_out"}, 32'(timed_out), 32'd0);
    for (int i = 0; i < n_exp; i++) begin
      read_buf(i, d);
      e = exp_q.pop_front();
      check($sformatf("%s_buf%0d", tag, i), d, e);
    end
  endtask

  int used;
  int steps;
  int sc_before, dc_before;

  initial begin
    // reset block
    reset = 1'b1; start = 1'b0; sweep_steps = 16'd0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_request_run", 32'(sampler_request_run), 32'd0);
    check("rst_phase_step", 32'(phase_step), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timed_out", 32'(timed_out), 32'd0);
    check("rst_steps_completed", 32'(steps_completed), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // four fixed results; a start while busy is ignored
    start_sweep(4, 1'b1, 0);
    repeat (10) @(negedge clk);
    sweep_steps = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(400, "four", used);
    verify_sweep(4, "four");

    // zero steps: immediate done; a start coinciding with done is ignored
    start_sweep(0, 1'b0, 0);
    check("zero_done_now", 32'(done), 32'd1);
    sweep_steps = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_start_on_done_ignored", 32'(busy), 32'd0);
    wait_idle(10, "zero", used);
    check("zero_done_latency", 32'(used <= 3), 32'd1);
    verify_sweep(0, "zero");

    // sampler busy at start: no request until running falls
    start_sweep($urandom_range(2, 5), 1'b0, 52);
    steps = int'(sweep_steps);
    repeat (40) @(negedge clk);
    check("hold_no_early_request", 32'(req_cnt), 32'd0);
    wait_idle(500, "hold", used);
    verify_sweep(steps, "hold");

    // randomized sweeps
    for (int r = 0; r < 3; r++) begin
      start_sweep($urandom_range(1, 24), 1'b0, 0);
      steps = int'(sweep_steps);
      wait_idle(60 * steps + 100, $sformatf("rand%0d", r), used);
      verify_sweep(steps, $sformatf("rand%0d", r));
    end

    // longer than the buffer: clamps to DEPTH runs
    start_sweep(300, 1'b0, 0);
    wait_idle(60 * 300 + 100, "clamp", used);
    verify_sweep(DEPTH, "clamp");

    // reset while settling after the second phase step
    start_sweep(10, 1'b0, 0);
    used = 0;
    while (step_cnt < 2 && used < 300) begin @(negedge clk); used++; end
    check("abort_reached_step2", 32'(step_cnt), 32'd2);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_steps_completed", 32'(steps_completed), 32'd0);
    sc_before = step_cnt; dc_before = done_cnt;
    repeat (40) @(negedge clk);
    check("abort_no_more_steps", 32'(step_cnt), 32'(sc_before));
    check("abort_no_done", 32'(done_cnt), 32'(dc_before));
    check("abort_done_zero", 32'(dc_before), 32'd0);
    start_sweep(5, 1'b0, 0);
    wait_idle(400, "after_abort", used);
    verify_sweep(5, "after_abort");

`ifdef SWEEP_TIMEOUT_EN
    // sampler never answers: watchdog ends the sweep
    mute = 1'b1;
    start_sweep(3, 1'b0, 0);
    wait_idle(400, "tmo", used);
    check("tmo_timed_out", 32'(timed_out), 32'd1);
    check("tmo_steps_completed", 32'(steps_completed), 32'd0);
    check("tmo_done_pulses", 32'(done_cnt), 32'd1);
    check("tmo_requests", 32'(req_cnt), 32'd1);
    check("tmo_latency", 32'((done_cyc - last_req_cyc) >= TMO - 2 && (done_cyc - last_req_cyc) <= TMO + 2), 32'd1);
    mute = 1'b0;
    start_sweep(2, 1'b0, 0);
    wait_idle(300, "tmo_clear", used);
    verify_sweep(2, "tmo_clear");
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ets_sweep_controller.md
# ets_sweep_controller

Sequences a full equivalent-time-sampling sweep around the offset sampler. For each ETS phase position it launches one sampler run, captures the resulting one-count into an on-chip result buffer, then steps the ETS PLL phase and waits for it to settle. The host reads the buffer afterwards through a registered read port, normally via the SPI register bridge.

## Interface
- `DEPTH`, 256: result buffer entries and maximum phase positions per sweep; power of two.
- `ADDR_W`, 8: log2(`DEPTH`).
- `SETTLE_CYCLES`, 16: idle `clk` cycles after each phase step before the next launch; ≥1.
- `TIMEOUT_CYCLES`, 1048576: watchdog limit per sampler run (only with `SWEEP_TIMEOUT_EN`).

Ports:
- `clk` in 1: sole clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begins a sweep when sampled high in IDLE; ignored otherwise.
- `sweep_steps` in 16: number of phase positions; latched on accepted `start`.
- `sampler_request_run` out 1: connects to the sampler's `request_run`.
- `sampler_running` in 1: from the sampler's `running`.
- `sampler_result_ready` in 1: from the sampler's `result_ready` (1-cycle pulse).
- `sampler_result` in 32: from the sampler's `result`.
- `phase_step` out 1: one-cycle pulse; advances the ETS PLL phase by one increment.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at sweep end.
- `timed_out` out 1: sticky error flag; cleared by the next accepted `start` or `reset`.
- `steps_completed` out 16: count of results written this sweep.
- `rd_addr` in `ADDR_W`: buffer read address.
- `rd_data` out 32: buffer word at `rd_addr`, registered.

## Operation
- States: IDLE, LAUNCH, WAIT_RESULT, STORE, STEP, SETTLE, DONE.
- IDLE: when `start` is high, latch `n = min(sweep_steps, DEPTH)`, clear `steps_completed` and `timed_out`, and go to LAUNCH. If `n == 0`, go to DONE instead.
- LAUNCH: wait until `sampler_running == 0`. Then register `sampler_request_run <= 1` for exactly one cycle and go to WAIT_RESULT. The request is a single pulse that is never held, so the sampler cannot relaunch when it returns to its wait state.
- WAIT_RESULT: on `sampler_result_ready`, capture `sampler_result` and go to STORE.
- STORE: write the captured word to buffer address `steps_completed[ADDR_W-1:0]` and increment `steps_completed`. If the new count equals `n`, go to DONE; otherwise go to STEP.
- STEP: pulse `phase_step` for one cycle, load the settle counter with `SETTLE_CYCLES`, and go to SETTLE.
- SETTLE: decrement the counter each cycle; at 0, go to LAUNCH.
- No phase step follows the final sample. Returning the PLL phase to its origin is the host's responsibility.
- DONE: pulse `done` for one cycle and go to IDLE.
- Buffer: single write port (controller), single registered read port (host). The read port is usable in any state.
  - A read and write to the same address in the same cycle returns the old data.
  - Buffer contents are not reset.
- `reset` mid-sweep: go to IDLE on the next edge. No further `phase_step` pulses; no `done` pulse. Buffer contents are retained but undefined for the aborted sweep.

## Timing
- Reset values:
  - `sampler_request_run`, `phase_step`, `busy`, `done`, `timed_out`: 0.
  - `steps_completed`: 0.
  - `rd_data`: 0.
- `start` sampled at edge k: `busy` is high from k+1.
- With the sampler idle, `sampler_request_run` is high during cycle k+2.
- `sampler_result_ready` at edge r: buffer write at edge r+2; `steps_completed` updates at r+2.
- `phase_step` is high during cycle r+3.
- Next `sampler_request_run` follows `SETTLE_CYCLES`+1 cycles after the `phase_step` cycle (sampler idle).
- `done` is high for one cycle after the final STORE; `busy` falls the cycle after `done`.
- `rd_data` is valid one cycle after `rd_addr` changes.
- A `start` that coincides with `done` is ignored; `start` must be re-presented in IDLE.

## Configuration
- `SWEEP_TIMEOUT_EN` defined:
  - A 32-bit watchdog clears on entry to WAIT_RESULT and counts while in that state.
  - On reaching `TIMEOUT_CYCLES`, set `timed_out` and go to DONE without writing the buffer.
  - `steps_completed` holds the number of valid entries written before the timeout.
- Undefined: no watchdog. WAIT_RESULT waits indefinitely and `timed_out` is tied to 0.

## Test plan
- `sweep_steps = 4`, sampler model returning 10, 20, 30, 40 -> buffer[0..3] = 10, 20, 30, 40; exactly 3 `phase_step` pulses; one `done`; `steps_completed = 4`.
- `sweep_steps = 0` -> `done` within 3 cycles of `start`; no `sampler_request_run`; no `phase_step`; `steps_completed = 0`.
- `sweep_steps = 300`, `DEPTH = 256` -> exactly 256 runs; last write at address 255; `steps_completed = 256`.
- Sampler model with `sampler_running` held high for 50 cycles at `start` -> `sampler_request_run` stays low until `running` falls, then pulses for exactly 1 cycle. Spacing between `phase_step` and the next request is ≥ `SETTLE_CYCLES`+1.
- `reset` asserted while in SETTLE at step 2 -> IDLE next cycle; `busy = 0`; no `done`; a new `start` sweeps correctly from address 0.
- `SWEEP_TIMEOUT_EN`, `TIMEOUT_CYCLES = 100`, sampler never returns a result -> `timed_out = 1` and `done` pulses at about 100 cycles into WAIT_RESULT; `steps_completed = 0`.
